bcd_countdown_timer: RTL and testbench

//  M:SS countdown timer that produces the sec_ones / sec_tens / mins BCD digits

---
 rtl/bcd_countdown_timer.sv | 132 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// M:SS BCD countdown timer with prescaled 1 s decrement, start/stop/clear/load control.
// Digits, running and done update one cycle after the controlling edge; zero is combinational.
// No backpressure: inputs are level-sampled every edge with priority clear > stop > load > start.
module bcd_countdown_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] ld_mins,
    input  logic [3:0] ld_sec_tens,
    input  logic [3:0] ld_sec_ones,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       running,
    output logic       zero,
    output logic       done
);

    localparam int PW = $clog2(TICKS_PER_SEC);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    ones_q, tens_q, mins_q;
    logic [3:0]    ones_nxt, tens_nxt, mins_nxt;
    logic [PW-1:0] presc_q, presc_nxt;
    logic          done_q, done_nxt;

    logic          tick;
    logic [3:0]    dec_ones, dec_tens, dec_mins;
    logic [3:0]    sat_ones, sat_tens, sat_mins;

    assign zero = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == 4'd0);
    assign tick = (state == RUN) && (presc_q == PW'(TICKS_PER_SEC - 1));

    // Borrow chain; never entered at 0:00 because RUN always leaves on reaching it.
    always_comb begin
        dec_ones = ones_q;
        dec_tens = tens_q;
        dec_mins = mins_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (tens_q != 4'd0) begin
                dec_tens = tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_mins = mins_q - 4'd1;
            end
        end
    end

    assign sat_ones = (ld_sec_ones > 4'd9) ? 4'd9 : ld_sec_ones;
    assign sat_tens = (ld_sec_tens > 4'd5) ? 4'd5 : ld_sec_tens;
    assign sat_mins = (ld_mins     > 4'd9) ? 4'd9 : ld_mins;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ones_nxt  = ones_q;
        tens_nxt  = tens_q;
        mins_nxt  = mins_q;
        presc_nxt = presc_q;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            ones_nxt  = 4'd0;
            tens_nxt  = 4'd0;
            mins_nxt  = 4'd0;
            presc_nxt = '0;
        end else if (stop) begin
            // Outside RUN a stop still masks load/start on the same edge.
            if (state == RUN) state_nxt = PAUSE;
        end else if (load && state != RUN) begin
            state_nxt = IDLE;
            ones_nxt  = sat_ones;
            tens_nxt  = sat_tens;
            mins_nxt  = sat_mins;
        end else if (start && state != RUN && !zero) begin
            state_nxt = RUN;
            presc_nxt = '0;
        end else if (state == RUN) begin
            if (tick) begin
                presc_nxt = '0;
                ones_nxt  = dec_ones;
                tens_nxt  = dec_tens;
                mins_nxt  = dec_mins;
                if (dec_ones == 4'd0 && dec_tens == 4'd0 && dec_mins == 4'd0) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end else begin
                presc_nxt = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            mins_q  <= 4'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            ones_q  <= ones_nxt;
            tens_q  <= tens_nxt;
            mins_q  <= mins_nxt;
            presc_q <= presc_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        sec_ones = ones_q;
        sec_tens = tens_q;
        mins     = mins_q;
        running  = (state == RUN);
        done     = done_q;
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: seconds-based reference model checked every cycle,
// plus directed scenarios with literal M:SS expectations.
module tb_bcd_countdown_timer;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [3:0] ld_mins = 4'd0, ld_sec_tens = 4'd0, ld_sec_ones = 4'd0;
    logic [3:0] sec_ones, sec_tens, mins;
    logic       running, zero, done;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    // Reference: remaining time in whole seconds, phase counter within the current second.
    int m_secs = 0;
    int m_mode = 0;     // 0 idle, 1 run, 2 pause, 3 done
    int m_phase = 0;
    bit m_done = 1'b0;

    bcd_countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .ld_mins(ld_mins), .ld_sec_tens(ld_sec_tens), .ld_sec_ones(ld_sec_ones),
        .start(start), .stop(stop), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
        .running(running), .zero(zero), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int lim(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!rst_n) begin
            m_secs = 0; m_mode = 0; m_phase = 0;
        end else if (clear) begin
            m_secs = 0; m_mode = 0; m_phase = 0;
        end else if (stop) begin
            if (m_mode == 1) m_mode = 2;
        end else if (load && m_mode != 1) begin
            m_secs = lim(ld_mins, 9) * 60 + lim(ld_sec_tens, 5) * 10 + lim(ld_sec_ones, 9);
            m_mode = 0;
        end else if (start && m_mode != 1 && m_secs != 0) begin
            m_mode = 1; m_phase = 0;
        end else if (m_mode == 1) begin
            m_phase++;
            if (m_phase == TPS) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = 3;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [14:0] act, exp;
            act = {mins, sec_tens, sec_ones, running, zero, done};
            exp = {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
                   m_mode == 1, m_secs == 0, m_done};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model_cycle t=%0t got m%h t%h o%h run%b z%b d%b want m%h t%h o%h run%b z%b d%b",
                         $time, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                         exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
            end
        end
    end

    task automatic chk_time(input string name, input logic [11:0] want);
        logic [11:0] got;
        got = {mins, sec_tens, sec_ones};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %h:%h%h want %h:%h%h", name,
                     got[11:8], got[7:4], got[3:0], want[11:8], want[7:4], want[3:0]);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; ld_mins = m; ld_sec_tens = t; ld_sec_ones = o;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        wait_n(2);
        rst_n = 1'b1;
        chk_time("reset_digits", 12'h000);
        chk_bit("reset_running", running, 1'b0);
        chk_bit("reset_done", done, 1'b0);
        chk_bit("reset_zero", zero, 1'b1);
        check_en = 1'b1;

        // Reset mid-countdown
        do_load(4'd3, 4'd2, 4'd7);
        do_start;
        wait_n(2);
        chk_time("run_3_27", 12'h327);
        chk_bit("run_running", running, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_time("rst_mid_run", 12'h000);
        chk_bit("rst_mid_run_running", running, 1'b0);
        chk_bit("rst_mid_run_done", done, 1'b0);

        // 0:12 down to 0:00
        do_load(4'd0, 4'd1, 4'd2);
        chk_time("load_0_12", 12'h012);
        do_start;
        wait_n(3);
        chk_time("before_first_tick", 12'h012);
        wait_n(1);
        chk_time("first_tick", 12'h011);
        wait_n(8);
        chk_time("borrow_0_09", 12'h009);
        wait_n(32);
        chk_time("at_0_01", 12'h001);
        chk_bit("at_0_01_done", done, 1'b0);
        wait_n(4);
        chk_time("reach_zero", 12'h000);
        chk_bit("reach_zero_done", done, 1'b1);
        chk_bit("reach_zero_running", running, 1'b0);
        wait_n(1);
        chk_bit("done_one_cycle", done, 1'b0);

        // Double borrow, then stop/resume at 0:45
        do_load(4'd1, 4'd0, 4'd0);
        do_start;
        wait_n(4);
        chk_time("double_borrow", 12'h059);
        chk_bit("double_borrow_running", running, 1'b1);
        wait_n(56);
        chk_time("at_0_45", 12'h045);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_n(20);
        chk_time("pause_hold", 12'h045);
        chk_bit("pause_running", running, 1'b0);
        do_start;
        wait_n(3);
        chk_time("resume_wait", 12'h045);
        wait_n(1);
        chk_time("resume_tick", 12'h044);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_bit("start_stop_pause", running, 1'b0);
        wait_n(8);
        chk_time("start_stop_hold", 12'h044);

        // Saturating load, load ignored in RUN, start at 0:00
        do_load(4'hA, 4'h7, 4'hF);
        chk_time("load_saturate", 12'h959);
        do_start;
        do_load(4'd1, 4'd2, 4'd3);
        chk_time("load_in_run_ignored", 12'h959);
        chk_bit("load_in_run_running", running, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_time("clear_digits", 12'h000);
        do_start;
        chk_bit("start_at_zero", running, 1'b0);
        wait_n(5);
        chk_time("start_at_zero_hold", 12'h000);

        // Clear exactly on the tick edge at 0:05
        do_load(4'd0, 4'd0, 4'd6);
        do_start;
        wait_n(4);
        chk_time("at_0_05", 12'h005);
        wait_n(3);
        chk_time("pre_tick_0_05", 12'h005);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_time("clear_on_tick", 12'h000);
        chk_bit("clear_on_tick_done", done, 1'b0);
        chk_bit("clear_on_tick_running", running, 1'b0);
        wait_n(2);
        chk_bit("clear_no_late_done", done, 1'b0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
